// File: rtl/mips_mem_pkg.sv
// Shared constants for the unified instruction/data memory path: default widths,
// arbiter state encoding and the load/store opcodes used by the pipeline.
package mips_mem_pkg;

    localparam int ADDR_W_DEF = 10;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        IF_ACC = 2'b01,
        DM_ACC = 2'b10
    } arb_state_t;

    localparam logic [5:0] LW = 6'b001000;
    localparam logic [5:0] SW = 6'b001001;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Single-port arbiter for the unified 1024x32 memory, DM has priority over IF; grant one cycle after request.
// Optional IF starvation guard: define MIPS_MEM_ARB_STARVE_GUARD_EN to force an IF grant after MAX_DM_BURST DM grants.
module mips_mem_arbiter
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_DM_BURST = 4
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic              halt,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (MAX_DM_BURST < 1) begin : g_bad_burst
        $error("MAX_DM_BURST must be at least 1");
    end

    arb_state_t        r_state;
    arb_state_t        w_next;
    logic              w_trip;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_if_rvalid;
    logic              r_dm_rvalid;

`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
    localparam int BURST_W = $clog2(MAX_DM_BURST + 1);
    logic [BURST_W-1:0] r_burst;

    assign w_trip = (r_burst == BURST_W'(MAX_DM_BURST));

    // Counts DM grants taken while IF is waiting; any IF grant or idle IF clears it.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_burst <= '0;
        end else if (!if_req || w_next == IF_ACC) begin
            r_burst <= '0;
        end else if (w_next == DM_ACC) begin
            r_burst <= r_burst + BURST_W'(1);
        end
    end
`else
    assign w_trip = 1'b0;
`endif

    always_comb begin
        w_next = IDLE;
        if (halt) begin
            w_next = IDLE;
        end else if (dm_req && !w_trip) begin
            w_next = DM_ACC;
        end else if (if_req) begin
            w_next = IF_ACC;
        end
    end

    // Memory command is captured with the grant decision so it lines up with the state.
    always_ff @(posedge clk1 or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_dm_rvalid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_if_rvalid <= (r_state == IF_ACC);
            r_dm_rvalid <= (r_state == DM_ACC) && !r_mem_we;
            case (w_next)
                DM_ACC: begin
                    r_mem_we    <= dm_we;
                    r_mem_addr  <= dm_addr;
                    r_mem_wdata <= dm_wdata;
                end
                IF_ACC: begin
                    r_mem_we   <= 1'b0;
                    r_mem_addr <= if_addr;
                end
                default: begin
                    r_mem_we <= 1'b0;
                end
            endcase
        end
    end

    assign if_gnt    = (r_state == IF_ACC);
    assign dm_gnt    = (r_state == DM_ACC);
    assign mem_en    = (r_state != IDLE);
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign if_rvalid = r_if_rvalid;
    assign dm_rvalid = r_dm_rvalid;
    assign if_rdata  = mem_rdata;
    assign dm_rdata  = mem_rdata;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Directed bench for mips_mem_arbiter with a synchronous-read memory model.
module tb_mips_mem_arbiter;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk1 = 1'b0;
    logic              rst;
    logic              halt;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [DATA_W-1:0] dm_rdata;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    logic [DATA_W-1:0] mem [0:1023];

    int total = 0;
    int bad   = 0;

    always #5 clk1 = ~clk1;

    mips_mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_DM_BURST(4)) dut (
        .clk1(clk1), .rst(rst), .halt(halt),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always @(posedge clk1) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr] <= mem_wdata;
            else        mem_rdata     <= mem[mem_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    initial begin
        for (int k = 0; k < 1024; k++) mem[k] = 32'h0;
        for (int k = 0; k < 4; k++) mem[k] = 32'h100 + k;
        mem[10'h200] = 32'hDEADBEEF;
        mem_rdata = '0;
        rst = 1'b1; halt = 1'b0;
        if_req = 1'b1; if_addr = '0;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h200; dm_wdata = '0;

        // reset holds everything quiet despite requests
        repeat (2) step();
        chk("rst_if_gnt", {31'b0, if_gnt}, 0);
        chk("rst_dm_gnt", {31'b0, dm_gnt}, 0);
        chk("rst_if_rvalid", {31'b0, if_rvalid}, 0);
        chk("rst_dm_rvalid", {31'b0, dm_rvalid}, 0);
        chk("rst_mem_en", {31'b0, mem_en}, 0);
        chk("rst_mem_we", {31'b0, mem_we}, 0);

        // IF-only back-to-back reads
        dm_req = 1'b0; if_addr = 0; rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("if_gnt", {31'b0, if_gnt}, 1);
            chk("if_mem_addr", {22'b0, mem_addr}, k);
            chk("if_mem_we", {31'b0, mem_we}, 0);
            if (k > 0) begin
                chk("if_rvalid", {31'b0, if_rvalid}, 1);
                chk("if_rdata", if_rdata, 32'h100 + k - 1);
            end
            if (k < 3) if_addr = ADDR_W'(k + 1);
            else       if_req  = 1'b0;
        end
        step();
        chk("if_last_rvalid", {31'b0, if_rvalid}, 1);
        chk("if_last_rdata", if_rdata, 32'h103);
        chk("if_last_gnt", {31'b0, if_gnt}, 0);
        step();
        chk("if_idle_rvalid", {31'b0, if_rvalid}, 0);
        chk("idle_mem_en", {31'b0, mem_en}, 0);

        // simultaneous requests: DM first
        if_req = 1'b1; if_addr = 2; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h200;
        step();
        chk("ct_dm_gnt", {31'b0, dm_gnt}, 1);
        chk("ct_if_gnt0", {31'b0, if_gnt}, 0);
        chk("ct_mem_addr", {22'b0, mem_addr}, 32'h200);
        dm_req = 1'b0;
        step();
        chk("ct_if_gnt1", {31'b0, if_gnt}, 1);
        chk("ct_dm_rvalid", {31'b0, dm_rvalid}, 1);
        chk("ct_dm_rdata", dm_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        step();
        chk("ct_if_rvalid", {31'b0, if_rvalid}, 1);
        chk("ct_if_rdata", if_rdata, 32'h102);
        chk("ct_dm_rvalid_off", {31'b0, dm_rvalid}, 0);

        // store then load to the same word
        dm_req = 1'b1; dm_we = 1'b1; dm_addr = 5; dm_wdata = 32'hA5A5A5A5;
        step();
        chk("st_gnt", {31'b0, dm_gnt}, 1);
        chk("st_mem_we", {31'b0, mem_we}, 1);
        chk("st_wdata", mem_wdata, 32'hA5A5A5A5);
        dm_we = 1'b0;
        step();
        chk("ld_gnt", {31'b0, dm_gnt}, 1);
        chk("ld_mem_we", {31'b0, mem_we}, 0);
        chk("st_no_rvalid", {31'b0, dm_rvalid}, 0);
        dm_req = 1'b0;
        step();
        chk("ld_rvalid", {31'b0, dm_rvalid}, 1);
        chk("ld_rdata", dm_rdata, 32'hA5A5A5A5);

        // halt during an IF grant
        if_req = 1'b1; if_addr = 3;
        step();
        chk("h_if_gnt", {31'b0, if_gnt}, 1);
        halt = 1'b1; dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h200;
        step();
        chk("h_if_rvalid", {31'b0, if_rvalid}, 1);
        chk("h_if_rdata", if_rdata, 32'h103);
        for (int k = 0; k < 3; k++) begin
            chk("h_no_if_gnt", {31'b0, if_gnt}, 0);
            chk("h_no_dm_gnt", {31'b0, dm_gnt}, 0);
            chk("h_mem_en", {31'b0, mem_en}, 0);
            step();
        end
        halt = 1'b0;
        step();
        chk("h_resume_dm", {31'b0, dm_gnt}, 1);
        dm_req = 1'b0;
        step();
        chk("h_resume_if", {31'b0, if_gnt}, 1);
        chk("h_resume_rdata", dm_rdata, 32'hDEADBEEF);
        if_req = 1'b0;
        step();

        // async reset in the middle of a read
        if_req = 1'b1; if_addr = 1;
        step();
        chk("ar_gnt", {31'b0, if_gnt}, 1);
        if_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_gnt_clr", {31'b0, if_gnt}, 0);
        chk("ar_mem_en", {31'b0, mem_en}, 0);
        step();
        chk("ar_no_rvalid", {31'b0, if_rvalid}, 0);
        rst = 1'b0;

        // sustained contention: guard decides whether IF ever gets in
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 10'h200; if_req = 1'b1; if_addr = 0;
        for (int i = 0; i < 10; i++) begin
            step();
`ifdef MIPS_MEM_ARB_STARVE_GUARD_EN
            chk("gd_seq", {30'b0, if_gnt, dm_gnt}, (i % 5 == 4) ? 32'd2 : 32'd1);
`else
            chk("gd_seq", {30'b0, if_gnt, dm_gnt}, 32'd1);
`endif
        end
        dm_req = 1'b0; if_req = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/mips_mem_arbiter.md
Name: mips_mem_arbiter

Overview:
- Single-port arbiter sharing the unified 1024x32 instruction/data memory between two requesters.
- Requesters: the IF stage (instruction reads) and the MEM stage (LW reads, SW writes).
- Replaces the current dual access to Mem, so fetch and load/store can never hit the memory in the same cycle.
- Registered grant FSM with fixed DM-over-IF priority. Optional starvation guard for IF.

Parameters:
- ADDR_W, 10, memory word-address width (1024 words).
- DATA_W, 32, data word width.
- MAX_DM_BURST, 4, consecutive DM grants allowed while IF is waiting (used only with the guard enabled).

Ports:
- clk1  in  1  single system clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- halt  in  1  HLT retired; blocks new grants.
- if_req  in  1  IF read request; held with if_addr until if_gnt.
- if_addr  in  ADDR_W  IF word address (PC).
- if_gnt  out  1  IF access issued this cycle.
- if_rvalid  out  1  if_rdata valid (cycle after if_gnt).
- if_rdata  out  DATA_W  instruction word.
- dm_req  in  1  MEM-stage request; held with dm_we/addr/wdata until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  ADDR_W  data word address (ALUOUT).
- dm_wdata  in  DATA_W  store data (B operand).
- dm_gnt  out  1  DM access issued this cycle.
- dm_rvalid  out  1  dm_rdata valid (cycle after a load grant).
- dm_rdata  out  DATA_W  load data (LMD).
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  synchronous read data, valid one cycle after mem_en with mem_we=0.

Behaviour:
- States:
  - IDLE: no access.
  - IF_ACC: if_gnt=1, mem_en=1, mem_we=0, mem_addr=if_addr.
  - DM_ACC: dm_gnt=1, mem_en=1, mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata.
- Decision each posedge, from any state, for the next state:
  - halt=1 -> IDLE.
  - else dm_req=1 (and guard not tripped) -> DM_ACC.
  - else if_req=1 -> IF_ACC.
  - else IDLE.
- Back-to-back grants allowed: throughput is 1 access per cycle.
- Grant latency: a request is granted no earlier than the cycle after it is first asserted.
- A requester deasserts req the cycle after gnt unless it wants another access. Because requests are held, a still-high req after gnt is a new request.
- Read return:
  - if_rvalid and dm_rvalid are registered flags, set the cycle after IF_ACC, or after DM_ACC with dm_we=0.
  - if_rdata and dm_rdata are driven from mem_rdata and are valid only while the matching rvalid is high.
  - Stores produce no rvalid.
- While idle: mem_addr and mem_wdata are don't-care, and mem_en=mem_we=0.
- Simultaneous if_req and dm_req: DM wins (an older instruction draining takes precedence).
- halt rising during an access: the in-flight access completes and its rvalid still fires the next cycle; no further grants. Deasserting halt resumes normal arbitration.
- Reset (asynchronous, any time, including mid-access):
  - state=IDLE; gnts, rvalids, mem_en and mem_we all 0; burst counter=0.
  - A read in flight when reset asserts never reports rvalid.
- Address wrap: none; addresses pass through unmodified.

Optional Feature:
- Macro: MIPS_MEM_ARB_STARVE_GUARD_EN.
- With the macro defined:
  - A counter of consecutive DM_ACC grants increments while if_req=1 and resets on any IF_ACC, or whenever if_req=0.
  - When it equals MAX_DM_BURST, the next grant goes to IF even if dm_req=1. The counter then clears.
- Without the macro: strict DM priority, no counter logic, and IF may starve indefinitely.

Decomposition:
- Package mips_mem_pkg:
  - ADDR_W / DATA_W defaults.
  - arbiter state encoding IDLE=2'b00, IF_ACC=2'b01, DM_ACC=2'b10.
  - opcode constants LW=6'b001000 and SW=6'b001001, shared with the pipeline.
- Sub-module: none required. The guard counter stays inline, under the macro.

Test Plan:
- Reset: rst=1 with if_req=dm_req=1 -> all gnts, rvalids and mem_en are 0. Release rst -> IF/DM arbitration starts on the next posedge.
- IF only: if_req=1, if_addr=0..3 stepping each grant, mem[k]=k+0x100 -> if_gnt every cycle, if_rvalid the cycle after each grant, if_rdata=0x100..0x103.
- Contention: if_req=1 and dm_req=1 (load, addr 0x200, mem=0xDEADBEEF) in the same cycle -> dm_gnt first, dm_rdata=0xDEADBEEF; if_gnt the following cycle.
- Store then load: dm_we=1, dm_addr=5, wdata=0xA5A5A5A5, then load addr 5 -> mem_we=1 once, no rvalid for the store, dm_rdata=0xA5A5A5A5.
- Halt mid-read: assert halt in the cycle of an IF_ACC grant -> if_rvalid still fires next cycle; no grants while halt=1 despite pending reqs.
- Guard (macro on, MAX_DM_BURST=4): dm_req and if_req held high -> grant sequence DM,DM,DM,DM,IF,DM... With the macro off -> DM only.
